conv_cfg_sequencer: RTL

Register-programming sequencer for the `conv_wrap` convolution IP. On a `start` pulse it issues the full configuration write sequence over the IP's AXI-Lite-style write channel: soft reset, enable, width, height, and K×K filter weights. It then waits for the end-of-frame beat on the IP's output stream and reports completion. It sits between the layer scheduler or host logic and `conv_wrap`, and replaces hand-driven register writes.

---
 rtl/conv_cfg_sequencer.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/conv_cfg_sequencer.sv
// conv_cfg_sequencer: on a start pulse, programs conv_wrap through its
// AXI-Lite-style write channel (soft reset, enable, width, height, KxK
// weights), then waits for the end-of-frame beat and pulses done.
module conv_cfg_sequencer #(
  parameter int KERNEL_SIZE = 3,
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                                          axi_clk,
  input  logic                                          axi_reset,
  input  logic                                          start,
  input  logic [15:0]                                   cfg_width,
  input  logic [15:0]                                   cfg_height,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] cfg_weights,
  input  logic                                          frame_last,
  output logic                                          busy,
  output logic                                          done,
  output logic                                          error,
  output logic [ADDR_WIDTH-1:0]                         m_axi_awaddr,
  output logic                                          m_axi_awvalid,
  input  logic                                          m_axi_awready,
  output logic [DATA_WIDTH-1:0]                         m_axi_wdata,
  output logic                                          m_axi_wvalid,
  input  logic                                          m_axi_wready,
  input  logic                                          m_axi_bvalid,
  output logic                                          m_axi_bready
);

  localparam int NUM_WEIGHTS = KERNEL_SIZE * KERNEL_SIZE;
  localparam int NUM_WRITES  = 4 + NUM_WEIGHTS;
  localparam int IDX_W       = $clog2(NUM_WRITES);
  localparam int CNT_W       = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WRITES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_RESP, S_WAIT_FRAME, S_DONE, S_ERROR
  } state_t;

  state_t                                  state;
  logic [IDX_W-1:0]                        idx;
  logic [CNT_W-1:0]                        cnt;
  logic                                    aw_done;
  logic                                    w_done;
  logic [15:0]                             width_q;
  logic [15:0]                             height_q;
  logic [NUM_WEIGHTS*DATA_WIDTH-1:0]       weights_q;

  logic                                    aw_hs;
  logic                                    w_hs;
  logic                                    aw_fin;
  logic                                    w_fin;
  logic [IDX_W-1:0]                        idx_next;

  assign aw_hs    = m_axi_awvalid & m_axi_awready;
  assign w_hs     = m_axi_wvalid & m_axi_wready;
  assign aw_fin   = aw_done | aw_hs;
  assign w_fin    = w_done | w_hs;
  assign idx_next = idx + IDX_W'(1);

  // Register address of write-list entry n.
  function automatic logic [ADDR_WIDTH-1:0] entry_addr(input logic [IDX_W-1:0] n);
    logic [31:0] a;
    case (n)
      IDX_W'(0): a = 32'd4;
      IDX_W'(1): a = 32'd0;
      IDX_W'(2): a = 32'd16;
      IDX_W'(3): a = 32'd20;
      default:   a = 32'd8 + 32'(n) * 32'd4;
    endcase
    return ADDR_WIDTH'(a);
  endfunction

  // Write data of entry n, taken from the configuration latched at start.
  function automatic logic [DATA_WIDTH-1:0] entry_data(input logic [IDX_W-1:0] n);
    logic [DATA_WIDTH-1:0] d;
    int                    wi;
    wi = int'(n) - 4;
    case (n)
      IDX_W'(0): d = DATA_WIDTH'(1);
      IDX_W'(1): d = DATA_WIDTH'(1);
      IDX_W'(2): d = DATA_WIDTH'(width_q);
      IDX_W'(3): d = DATA_WIDTH'(height_q);
      default:   d = weights_q[wi*DATA_WIDTH +: DATA_WIDTH];
    endcase
    return d;
  endfunction

  // Capture the configuration when a start is accepted; frozen while busy.
  always_ff @(posedge axi_clk) begin
    if (start && (state == S_IDLE || state == S_ERROR)) begin
      width_q   <= cfg_width;
      height_q  <= cfg_height;
      weights_q <= cfg_weights;
    end
  end

  // Sequencer FSM: issue each write, await its response, then await end of frame.
  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      state         <= S_IDLE;
      idx           <= '0;
      cnt           <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_ERROR: begin
          if (start) begin
            idx     <= '0;
            cnt     <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            if (cfg_width == 16'd0 || cfg_height == 16'd0) begin
              state <= S_ERROR;
              error <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= S_ISSUE;
              error <= 1'b0;
              busy  <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          // Each channel raises its valid once per entry and drops it after its own handshake.
          if (aw_hs) begin
            m_axi_awvalid <= 1'b0;
            aw_done       <= 1'b1;
          end else if (!aw_done && !m_axi_awvalid) begin
            m_axi_awvalid <= 1'b1;
            m_axi_awaddr  <= entry_addr(idx);
          end
          if (w_hs) begin
            m_axi_wvalid <= 1'b0;
            w_done       <= 1'b1;
          end else if (!w_done && !m_axi_wvalid) begin
            m_axi_wvalid <= 1'b1;
            m_axi_wdata  <= entry_data(idx);
          end
          if (aw_fin && w_fin) begin
            state        <= S_RESP;
            m_axi_bready <= 1'b1;
            cnt          <= '0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
          end else if (aw_hs || w_hs) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            state         <= S_ERROR;
            error         <= 1'b1;
            busy          <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            cnt           <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            cnt          <= '0;
            if (idx == LAST_IDX) begin
              state <= S_WAIT_FRAME;
            end else begin
              // Present the next entry straight away so each write costs two cycles.
              idx           <= idx_next;
              state         <= S_ISSUE;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              m_axi_awaddr  <= entry_addr(idx_next);
              m_axi_wdata   <= entry_data(idx_next);
            end
          end else if (cnt == CNT_LAST) begin
            state        <= S_ERROR;
            error        <= 1'b1;
            busy         <= 1'b0;
            m_axi_bready <= 1'b0;
            cnt          <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_WAIT_FRAME: begin
          cnt <= '0;
          if (frame_last) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
